// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: holds one instruction, reads both source
// operands from a registered regfile and resolves writeback hazards.
module reg_read_stage #(
   parameter int INT32W       = 32,
   parameter int REGFILE_SIZE = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [INT32W-1:0]       inInstr,
   output logic [REGFILE_SIZE-1:0] rfRs1,
   output logic [REGFILE_SIZE-1:0] rfRs2,
   input  logic [INT32W-1:0]       rfDataRs1,
   input  logic [INT32W-1:0]       rfDataRs2,
   input  logic                    wbValid,
   input  logic [REGFILE_SIZE-1:0] wbRd,
   input  logic [INT32W-1:0]       wbData,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [INT32W-1:0]       outInstr,
   output logic [REGFILE_SIZE-1:0] outRd,
   output logic [INT32W-1:0]       outRs1Data,
   output logic [INT32W-1:0]       outRs2Data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [REGFILE_SIZE-1:0] REG_ZERO = {REGFILE_SIZE{1'b0}};
   localparam logic [INT32W-1:0]       DATA_ZERO = {INT32W{1'b0}};

   state_t                  state_q, state_d;
   logic [INT32W-1:0]       instr_q, instr_d;
   logic [INT32W-1:0]       op1_q, op1_d;
   logic [INT32W-1:0]       op2_q, op2_d;
   logic                    fwd1_vld_q, fwd1_vld_d;
   logic                    fwd2_vld_q, fwd2_vld_d;
   logic [INT32W-1:0]       fwd1_data_q, fwd1_data_d;
   logic [INT32W-1:0]       fwd2_data_q, fwd2_data_d;
   logic                    out_valid_q;

   logic                    accept_s;
   logic [REGFILE_SIZE-1:0] in_rs1_s, in_rs2_s;
   logic [REGFILE_SIZE-1:0] held_rs1_s, held_rs2_s;

   // True when a writeback this edge targets a real (non-x0) source register.
   function automatic logic wb_hits(
      input logic                    wb_valid,
      input logic [REGFILE_SIZE-1:0] wb_rd,
      input logic [REGFILE_SIZE-1:0] rs
   );
      return wb_valid && (wb_rd == rs) && (rs != REG_ZERO);
   endfunction

   // Capture-edge operand priority: x0, live writeback, pending forward, regfile.
   function automatic logic [INT32W-1:0] resolve(
      input logic [REGFILE_SIZE-1:0] rs,
      input logic                    wb_valid,
      input logic [REGFILE_SIZE-1:0] wb_rd,
      input logic [INT32W-1:0]       wb_data,
      input logic                    fwd_vld,
      input logic [INT32W-1:0]       fwd_data,
      input logic [INT32W-1:0]       rf_data
   );
      logic [INT32W-1:0] val;
      if (rs == REG_ZERO) begin
         val = DATA_ZERO;
      end else if (wb_valid && (wb_rd == rs)) begin
         val = wb_data;
      end else if (fwd_vld) begin
         val = fwd_data;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

   assign in_rs1_s   = inInstr[15 +: REGFILE_SIZE];
   assign in_rs2_s   = inInstr[20 +: REGFILE_SIZE];
   assign held_rs1_s = instr_q[15 +: REGFILE_SIZE];
   assign held_rs2_s = instr_q[20 +: REGFILE_SIZE];

   assign rfRs1 = in_rs1_s;
   assign rfRs2 = in_rs2_s;

   // inReady is a function of state and outReady only, never of inValid.
   assign inReady  = (state_q == IDLE) || ((state_q == FULL) && outReady);
   assign accept_s = inReady && inValid;

   assign outValid   = out_valid_q;
   assign outInstr   = instr_q;
   assign outRd      = instr_q[7 +: REGFILE_SIZE];
   assign outRs1Data = op1_q;
   assign outRs2Data = op2_q;

   // Next-state, instruction latch, accept-edge forwards and operand capture.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      fwd1_vld_d  = fwd1_vld_q;
      fwd2_vld_d  = fwd2_vld_q;
      fwd1_data_d = fwd1_data_q;
      fwd2_data_d = fwd2_data_q;

      // The regfile returns the pre-write value for a write at the accept edge.
      if (accept_s) begin
         instr_d     = inInstr;
         fwd1_vld_d  = wb_hits(wbValid, wbRd, in_rs1_s);
         fwd2_vld_d  = wb_hits(wbValid, wbRd, in_rs2_s);
         fwd1_data_d = wb_hits(wbValid, wbRd, in_rs1_s) ? wbData : DATA_ZERO;
         fwd2_data_d = wb_hits(wbValid, wbRd, in_rs2_s) ? wbData : DATA_ZERO;
      end else begin
         instr_d     = instr_q;
         fwd1_vld_d  = fwd1_vld_q;
         fwd2_vld_d  = fwd2_vld_q;
      end

      case (state_q)
         IDLE: begin
            if (inValid) begin
               state_d = READ;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            state_d = FULL;
            op1_d = resolve(held_rs1_s, wbValid, wbRd, wbData,
                            fwd1_vld_q, fwd1_data_q, rfDataRs1);
            op2_d = resolve(held_rs2_s, wbValid, wbRd, wbData,
                            fwd2_vld_q, fwd2_data_q, rfDataRs2);
         end
         FULL: begin
            if (outReady) begin
               if (inValid) begin
                  state_d = READ;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               // Held operands must track writebacks while we stall.
               state_d = FULL;
               if (wb_hits(wbValid, wbRd, held_rs1_s)) begin
                  op1_d = wbData;
               end else begin
                  op1_d = op1_q;
               end
               if (wb_hits(wbValid, wbRd, held_rs2_s)) begin
                  op2_d = wbData;
               end else begin
                  op2_d = op2_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, payload and forward registers; reset discards any held instruction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         instr_q     <= DATA_ZERO;
         op1_q       <= DATA_ZERO;
         op2_q       <= DATA_ZERO;
         fwd1_vld_q  <= 1'b0;
         fwd2_vld_q  <= 1'b0;
         fwd1_data_q <= DATA_ZERO;
         fwd2_data_q <= DATA_ZERO;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         fwd1_vld_q  <= fwd1_vld_d;
         fwd2_vld_q  <= fwd2_vld_d;
         fwd1_data_q <= fwd1_data_d;
         fwd2_data_q <= fwd2_data_d;
         out_valid_q <= (state_d == FULL);
      end
   end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage with a registered-read regfile model.
module tb_reg_read_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] inInstr = 32'h0;
   logic [4:0]  rfRs1, rfRs2;
   logic [31:0] rfDataRs1, rfDataRs2;
   logic        wbValid = 1'b0;
   logic [4:0]  wbRd = 5'd0;
   logic [31:0] wbData = 32'h0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] outInstr;
   logic [4:0]  outRd;
   logic [31:0] outRs1Data, outRs2Data;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs [32];

   reg_read_stage #(.INT32W(32), .REGFILE_SIZE(5)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inInstr(inInstr),
      .rfRs1(rfRs1), .rfRs2(rfRs2), .rfDataRs1(rfDataRs1), .rfDataRs2(rfDataRs2),
      .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
      .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outRd(outRd),
      .outRs1Data(outRs1Data), .outRs2Data(outRs2Data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      case (i)
         0: return 32'h0000_DEAD;
         1: return 32'h0000_0101;
         2: return 32'h0000_0202;
         3: return 32'h0000_0303;
         4: return 32'h0000_0404;
         5: return 32'h0000_0011;
         6: return 32'h0000_0022;
         7: return 32'h0000_0077;
         default: return 32'h0;
      endcase
   endfunction

   // Registered-read regfile; x0 deliberately holds junk to exercise the x0 rule.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
      end else if (wbValid && wbRd != 5'd0) begin
         regs[wbRd] <= wbData;
      end
      rfDataRs1 <= regs[rfRs1];
      rfDataRs2 <= regs[rfRs2];
   end

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      inValid = 1'b1;
      inInstr = mk(5'd7, 5'd5, 5'd6);
      tick(); tick(); tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got %0b exp 0", outValid); end
      checks++; if (outInstr !== 32'h0) begin errors++; $display("FAIL rst_outInstr got %h exp 0", outInstr); end
      checks++; if (outRd !== 5'd0) begin errors++; $display("FAIL rst_outRd got %0d exp 0", outRd); end
      checks++; if (outRs1Data !== 32'h0 || outRs2Data !== 32'h0) begin errors++; $display("FAIL rst_ops got %h %h exp 0 0", outRs1Data, outRs2Data); end
      checks++; if (rfRs1 !== 5'd5 || rfRs2 !== 5'd6) begin errors++; $display("FAIL rf_addr got %0d %0d exp 5 6", rfRs1, rfRs2); end
      inValid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_release_inReady got %0b exp 1", inReady); end
      tick();
   endtask

   task automatic test_add();
      inInstr = mk(5'd7, 5'd5, 5'd6);
      inValid = 1'b1;
      outReady = 1'b1;
      tick();
      inValid = 1'b0;
      checks++; if (outValid !== 1'b0 || inReady !== 1'b0) begin errors++; $display("FAIL add_read got v=%0b r=%0b exp 0 0", outValid, inReady); end
      tick();
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", outValid); end
      checks++; if (outRs1Data !== 32'h11) begin errors++; $display("FAIL add_rs1 got %h exp 11", outRs1Data); end
      checks++; if (outRs2Data !== 32'h22) begin errors++; $display("FAIL add_rs2 got %h exp 22", outRs2Data); end
      checks++; if (outRd !== 5'd7) begin errors++; $display("FAIL add_rd got %0d exp 7", outRd); end
      checks++; if (outInstr !== 32'h0062_83B3) begin errors++; $display("FAIL add_instr got %h exp 006283b3", outInstr); end
      tick();
      checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL add_idle got v=%0b r=%0b exp 0 1", outValid, inReady); end
   endtask

   task automatic test_accept_bypass();
      inInstr = mk(5'd8, 5'd5, 5'd6);
      inValid = 1'b1;
      wbValid = 1'b1; wbRd = 5'd5; wbData = 32'hAA;
      tick();
      inValid = 1'b0; wbValid = 1'b0;
      tick();
      checks++; if (outRs1Data !== 32'hAA) begin errors++; $display("FAIL accept_fwd_rs1 got %h exp aa", outRs1Data); end
      checks++; if (outRs2Data !== 32'h22) begin errors++; $display("FAIL accept_fwd_rs2 got %h exp 22", outRs2Data); end
      tick();
   endtask

   task automatic test_read_bypass();
      inInstr = mk(5'd9, 5'd5, 5'd6);
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      wbValid = 1'b1; wbRd = 5'd6; wbData = 32'hBB;
      tick();
      wbValid = 1'b0;
      outReady = 1'b0;
      checks++; if (outRs2Data !== 32'hBB) begin errors++; $display("FAIL read_fwd_rs2 got %h exp bb", outRs2Data); end
      checks++; if (outRs1Data !== 32'hAA) begin errors++; $display("FAIL read_fwd_rs1 got %h exp aa", outRs1Data); end
      wbValid = 1'b1; wbRd = 5'd6; wbData = 32'hCC;
      tick();
      wbValid = 1'b0;
      checks++; if (outRs2Data !== 32'hCC) begin errors++; $display("FAIL full_wb_rs2 got %h exp cc", outRs2Data); end
      checks++; if (outRs1Data !== 32'hAA) begin errors++; $display("FAIL full_wb_rs1 got %h exp aa", outRs1Data); end
      checks++; if (outInstr !== mk(5'd9, 5'd5, 5'd6) || outValid !== 1'b1) begin errors++; $display("FAIL full_wb_hold got %h v=%0b exp %h v=1", outInstr, outValid, mk(5'd9, 5'd5, 5'd6)); end
      outReady = 1'b1;
      tick();
   endtask

   task automatic test_x0();
      inInstr = mk(5'd10, 5'd0, 5'd0);
      inValid = 1'b1;
      wbValid = 1'b1; wbRd = 5'd0; wbData = 32'hFF;
      tick();
      inValid = 1'b0;
      tick();
      wbValid = 1'b0;
      checks++; if (outRs1Data !== 32'h0 || outRs2Data !== 32'h0) begin errors++; $display("FAIL x0_ops got %h %h exp 0 0", outRs1Data, outRs2Data); end
      tick();
   endtask

   task automatic test_same_src();
      inInstr = mk(5'd11, 5'd7, 5'd7);
      inValid = 1'b1;
      wbValid = 1'b1; wbRd = 5'd7; wbData = 32'h99;
      tick();
      inValid = 1'b0; wbValid = 1'b0;
      tick();
      checks++; if (outRs1Data !== 32'h99 || outRs2Data !== 32'h99) begin errors++; $display("FAIL same_src got %h %h exp 99 99", outRs1Data, outRs2Data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] instrs [3];
      logic [31:0] exp1 [3];
      logic [31:0] exp2 [3];
      instrs[0] = mk(5'd12, 5'd1, 5'd2); exp1[0] = 32'h101; exp2[0] = 32'h202;
      instrs[1] = mk(5'd13, 5'd3, 5'd4); exp1[1] = 32'h303; exp2[1] = 32'h404;
      instrs[2] = mk(5'd14, 5'd2, 5'd3); exp1[2] = 32'h202; exp2[2] = 32'h303;
      outReady = 1'b1;
      inValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         inInstr = instrs[k];
         checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0b exp 1", k, inReady); end
         tick();
         inInstr = mk(5'd31, 5'd31, 5'd31);
         checks++; if (inReady !== 1'b0 || outValid !== 1'b0) begin errors++; $display("FAIL b2b_read[%0d] got r=%0b v=%0b exp 0 0", k, inReady, outValid); end
         tick();
         checks++; if (outValid !== 1'b1 || outInstr !== instrs[k]) begin errors++; $display("FAIL b2b_out[%0d] got v=%0b %h exp 1 %h", k, outValid, outInstr, instrs[k]); end
         checks++; if (outRs1Data !== exp1[k] || outRs2Data !== exp2[k]) begin errors++; $display("FAIL b2b_ops[%0d] got %h %h exp %h %h", k, outRs1Data, outRs2Data, exp1[k], exp2[k]); end
      end
      inValid = 1'b0;
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL inready_indep got %0b exp 1", inReady); end
      inValid = 1'b1;
      inInstr = mk(5'd15, 5'd4, 5'd1);
      tick();
      inInstr = mk(5'd16, 5'd1, 5'd1);
      tick();
      outReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0b exp 0", k, inReady); end
         checks++; if (outValid !== 1'b1 || outInstr !== mk(5'd15, 5'd4, 5'd1) || outRd !== 5'd15) begin errors++; $display("FAIL stall_hold[%0d] got v=%0b %h rd=%0d", k, outValid, outInstr, outRd); end
         checks++; if (outRs1Data !== 32'h404 || outRs2Data !== 32'h101) begin errors++; $display("FAIL stall_ops[%0d] got %h %h exp 404 101", k, outRs1Data, outRs2Data); end
         tick();
      end
      inValid = 1'b0;
      outReady = 1'b1;
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL stall_drain got %0b exp 0", outValid); end
   endtask

   task automatic test_reset_read();
      int seen;
      inInstr = mk(5'd17, 5'd1, 5'd2);
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (outValid !== 1'b0 || outInstr !== 32'h0) begin errors++; $display("FAIL rst_read got v=%0b %h exp 0 0", outValid, outInstr); end
      tick();
      rst = 1'b1;
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_read_inReady got %0b exp 1", inReady); end
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (outValid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_read_no_out got %0d exp 0", seen); end
   endtask

   initial begin
      #1;
      test_reset();
      test_add();
      test_accept_bypass();
      test_read_bypass();
      test_x0();
      test_same_src();
      test_back_to_back();
      test_reset_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 SHALL have parameter INT32W, default 32: operand/instruction width.
REQ-002 SHALL have parameter REGFILE_SIZE, default 5: register index width.
REQ-003 SHALL have a single clock `clk`; reset `rst` is asynchronous and active-low.
REQ-004 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  async active-low reset
- inValid  in  1  upstream instruction valid
- inReady  out  1  stage accepts instruction this cycle
- inInstr  in  INT32W  RV32 instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7]
- rfRs1  out  REGFILE_SIZE  regfile read address 1
- rfRs2  out  REGFILE_SIZE  regfile read address 2
- rfDataRs1  in  INT32W  regfile read data 1, registered (valid the cycle after the address edge)
- rfDataRs2  in  INT32W  regfile read data 2, registered
- wbValid  in  1  writeback committing to the regfile at this edge
- wbRd  in  REGFILE_SIZE  writeback destination
- wbData  in  INT32W  writeback value
- outValid  out  1  operands valid downstream
- outReady  in  1  downstream accepts
- outInstr  out  INT32W  held instruction
- outRd  out  REGFILE_SIZE  held rd field
- outRs1Data  out  INT32W  resolved rs1 operand
- outRs2Data  out  INT32W  resolved rs2 operand

Function
REQ-005 SHALL drive rfRs1 and rfRs2 combinationally from inInstr[19:15] and inInstr[24:20] in every cycle.
REQ-006 SHALL implement a three-state FSM with states IDLE, READ and FULL.
REQ-007 IDLE SHALL behave as follows: inReady=1 and outValid=0; on an edge with inValid=1, latch inInstr and go to READ.
REQ-008 READ SHALL behave as follows: inReady=0 and outValid=0; at the next edge, capture both operands into the output registers and go to FULL (one-cycle regfile latency).
REQ-009 FULL SHALL behave as follows: outValid=1 and inReady=outReady; outReady&inValid -> READ (latch the new instruction); outReady&~inValid -> IDLE; ~outReady -> stay in FULL.
REQ-010 Minimum latency from the accept edge to outValid=1 SHALL be 2 cycles; peak throughput SHALL be one instruction per 2 cycles.
REQ-011 Accept-edge bypass: if wbValid and wbRd==rsN!=0 at the accept edge, the stage SHALL latch wbData as a pending forward for operand N, because the regfile returns the pre-write value.
REQ-012 Capture-edge priority per operand SHALL be: rsN==0 -> 0; else wbValid&wbRd==rsN -> wbData; else pending forward -> its latched data; else rfDataRsN.
REQ-013 While in FULL without handoff, a writeback with wbRd==rsN!=0 SHALL overwrite outRsNData at that edge.
REQ-014 When rs1==rs2, both operands SHALL receive identical forwarded values.
REQ-015 Operand x0 SHALL always read 0, regardless of rfData or writebacks to index 0.
REQ-016 outInstr, outRd, outRs1Data and outRs2Data SHALL be stable while outValid=1 and outReady=0, except for the updates required by REQ-013.
REQ-017 inReady SHALL NOT depend combinationally on inValid.

Reset
REQ-018 While rst=0, FSM=IDLE, outValid=0, and outInstr/outRd/outRs1Data/outRs2Data/pending forwards SHALL all be 0.
REQ-019 Reset asserted in READ or FULL SHALL discard the instruction; no output handshake occurs for it.
REQ-020 After rst deasserts, inReady SHALL be 1 in the first cycle.

Verification
REQ-021 The bench SHALL cover: regfile x5=0x11, x6=0x22; accept add x7,x5,x6, outReady=1 -> outValid on the 2nd cycle after accept, outRs1Data=0x11, outRs2Data=0x22, outRd=7.
REQ-022 The bench SHALL cover: wbValid, wbRd=5, wbData=0xAA at the accept edge of an instruction with rs1=5 -> outRs1Data=0xAA (not the stale value).
REQ-023 The bench SHALL cover: writeback x6=0xBB on the READ-cycle edge -> outRs2Data=0xBB; then, with outReady=0 in FULL, writeback x6=0xCC -> outRs2Data becomes 0xCC, outInstr unchanged.
REQ-024 The bench SHALL cover: instruction with rs1=0, rs2=0 and wbValid, wbRd=0, wbData=0xFF -> both operands 0.
REQ-025 The bench SHALL cover: back-to-back inValid with outReady=1 -> accepts every 2 cycles and outValid pulses each handoff; with outReady held 0 for 5 cycles -> inReady=0 and outputs held.
REQ-026 The bench SHALL cover: rst=0 asserted during READ -> outValid=0 immediately, and no output for that instruction after release.
